// File: rtl/rop_trace_pkg.sv
// Shared types and defaults for the branch-trace writer that feeds the ROP detector.
package rop_trace_pkg;

    localparam int unsigned DATA_W_DFLT = 32;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_CALL = 2'd1,
        BR_RET  = 2'd2,
        BR_DJMP = 2'd3
    } br_type_t;

endpackage

// File: rtl/rop_trace_ring.sv
// Small power-of-two ring buffer with head/tail/count control.
// A push into a full ring is accepted only when a pop happens in the same cycle.
module rop_trace_ring
    import rop_trace_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = DATA_W_DFLT
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iPush,
    input  logic [DATA_W-1:0]        iPush_Data,
    input  logic                     iPop,
    output logic [DATA_W-1:0]        oRd_Data,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic                     oFull,
    output logic                     oEmpty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic              full, empty, do_push, do_pop;

    always_comb begin
        full    = (count_q == OCC_W'(DEPTH));
        empty   = (count_q == '0);
        do_pop  = iPop & ~empty;
        do_push = iPush & (~full | do_pop);
        // Pointers wrap naturally because DEPTH is a power of two.
        head_d  = head_q + PTR_W'(do_pop);
        tail_d  = tail_q + PTR_W'(do_push);
        count_d = count_q + OCC_W'(do_push) - OCC_W'(do_pop);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge iClk) begin
        if (do_push) begin
            mem_q[tail_q] <= iPush_Data;
        end
    end

    always_comb begin
        oRd_Data = empty ? '0 : mem_q[head_q];
        oCount   = count_q;
        oFull    = full;
        oEmpty   = empty;
    end

endmodule

// File: rtl/rop_trace_writer.sv
// Producer side of the branch-trace FIFO: filters committed branch targets, buffers
// them in a ring so back-pressure never stalls commit, and counts dropped targets.
module rop_trace_writer
    import rop_trace_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iTrace_En,
    input  logic                   iFilter_Djmp,
    input  logic                   iBr_Valid,
    input  br_type_t               iBr_Type,
    input  logic [DATA_W-1:0]      iBr_Target,
    input  logic                   iFifo_Full,
    output logic                   oFifo_WrEn,
    output logic [DATA_W-1:0]      oFifo_Data,
    input  logic                   iClr_Ovf,
    output logic                   oOverflow,
    output logic [CNT_W-1:0]       oDrop_Cnt,
    output logic [$clog2(DEPTH):0] oPending
);

    logic              acc, pop, drop;
    logic              ring_full, ring_empty;
    logic [DATA_W-1:0] ring_data;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    always_comb begin
        acc  = iTrace_En & iBr_Valid & (iBr_Type != BR_NONE)
             & ~(iFilter_Djmp & (iBr_Type == BR_DJMP));
        pop  = ~ring_empty & ~iFifo_Full;
        drop = acc & ring_full & ~pop;
    end

    rop_trace_ring #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ring (
        .iClk       (iClk),
        .iRst       (iRst),
        .iPush      (acc),
        .iPush_Data (iBr_Target),
        .iPop       (pop),
        .oRd_Data   (ring_data),
        .oCount     (oPending),
        .oFull      (ring_full),
        .oEmpty     (ring_empty)
    );

    // A drop in the same cycle as a clear restarts the count at one.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (iClr_Ovf) begin
                drop_cnt_d = CNT_W'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end else if (iClr_Ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        oFifo_WrEn = pop;
        oFifo_Data = ring_data;
        oOverflow  = overflow_q;
        oDrop_Cnt  = drop_cnt_q;
    end

endmodule

// File: doc/rop_trace_writer.md
Name: rop_trace_writer

Overview:
- Producer end of the branch-trace FIFO that feeds the ROP detector.
- Captures committed control-flow targets (call, return, direct jump) from the CPU commit port.
- Optionally filters direct jumps, buffers targets in a small ring so FIFO back-pressure does not stall commit, and pushes raw 32-bit target addresses into the FIFO.
- Drops targets on buffer overflow and reports the drops.

Parameters:
DATA_W, 32, width of a branch target address / FIFO word
DEPTH, 4, ring-buffer entries (power of two, >=2)
CNT_W, 8, width of saturating drop counter

Ports:
iClk  in  1  clock
iRst  in  1  synchronous active-high reset
iTrace_En  in  1  1 = accept branch events; 0 = ignore new events, buffer keeps draining
iFilter_Djmp  in  1  1 = discard BR_DJMP events
iBr_Valid  in  1  committed branch event present this cycle
iBr_Type  in  2  branch type (rop_trace_pkg::br_type_t)
iBr_Target  in  DATA_W  branch target address
iFifo_Full  in  1  downstream FIFO full
oFifo_WrEn  out  1  write strobe to FIFO
oFifo_Data  out  DATA_W  FIFO write data
iClr_Ovf  in  1  clears oOverflow and oDrop_Cnt
oOverflow  out  1  sticky: at least one target dropped
oDrop_Cnt  out  CNT_W  saturating count of dropped targets
oPending  out  $clog2(DEPTH)+1  current ring occupancy

Behaviour:
- Reset (synchronous, iRst=1 at posedge): ring emptied (head=tail=count=0), oOverflow=0, oDrop_Cnt=0. Consequently oFifo_WrEn=0, oPending=0, oFifo_Data=0 (zero output data when empty). Reset mid-operation discards all pending entries; none are written afterward.
- Accept condition: acc = iTrace_En & iBr_Valid & (iBr_Type!=BR_NONE) & !(iFilter_Djmp & iBr_Type==BR_DJMP).
- Write port (combinational):
  - oFifo_WrEn = (count!=0) & !iFifo_Full.
  - oFifo_Data = ring[head] when count!=0, else 0.
  - A write takes effect at the posedge where oFifo_WrEn=1 (pop).
- Push: on acc, iBr_Target is stored at ring[tail] if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle (full + pop + push allowed; count unchanged).
- Drop: acc with count==DEPTH and no pop. Target discarded, oOverflow<=1, oDrop_Cnt increments, saturating at 2^CNT_W-1.
- Latency: an event accepted at edge N with empty ring and iFifo_Full=0 gives oFifo_WrEn=1 and oFifo_Data=target during cycle N..N+1; the FIFO captures it at edge N+1. Minimum latency is 1 cycle. Ordering is strict FIFO.
- Empty ring with simultaneous acc: no bypass; the event is written the following cycle.
- Throughput: 1 event/cycle sustained while iFifo_Full=0.
- Pointers wrap modulo DEPTH. count = pushes - pops, range 0..DEPTH. oPending = count.
- iClr_Ovf=1: oOverflow<=0, oDrop_Cnt<=0. If a drop occurs in the same cycle, the drop wins: oOverflow<=1, oDrop_Cnt<=1.
- iTrace_En deasserted: no new pushes; pending entries still drain normally.
- iBr_Type not BR_NONE with iBr_Valid=0: ignored.
- No internal state machine beyond ring control: the ring is in EMPTY (count=0), PARTIAL, or FULL (count=DEPTH); transitions follow the push/pop rules above.

Decomposition:
- Package rop_trace_pkg holds:
  - br_type_t enum: BR_NONE=2'd0, BR_CALL=2'd1, BR_RET=2'd2, BR_DJMP=2'd3
  - DATA_W default constant
- Sub-module rop_trace_ring (parameterized DEPTH/DATA_W): storage, head/tail/count, push/pop/full/empty.
- rop_trace_writer adds accept filtering, drop/overflow logic, and the FIFO handshake.

Test Plan:
1. Reset then single CALL target 32'h80000010, iFifo_Full=0 -> next cycle oFifo_WrEn=1, oFifo_Data=32'h80000010; oPending returns to 0; no drops.
2. iFilter_Djmp=1, sequence CALL 32'h80000000, DJMP 32'h00001234, RET 32'h80000004 -> FIFO receives exactly 32'h80000000 then 32'h80000004, in that order. Repeat with iFilter_Djmp=0 -> all three written in order.
3. iFifo_Full=1, push 6 consecutive targets A..F (DEPTH=4) -> oPending=4, oOverflow=1, oDrop_Cnt=2. Release Full -> A,B,C,D written on 4 consecutive cycles; E and F never appear.
4. Ring full (count=4), iFifo_Full=0, accepted event G in the same cycle as a pop -> no drop, oPending stays 4, G emerges after the 4 older entries.
5. iClr_Ovf=1 concurrent with a drop -> oOverflow=1, oDrop_Cnt=1. iClr_Ovf alone next cycle -> both clear to 0.
6. Two entries pending, iRst=1 for one cycle mid-drain -> oFifo_WrEn=0 and oPending=0 the cycle after reset; the pending entries are never written. iTrace_En=0 with valid events -> nothing is pushed.
